// File: rtl/ch_pkg.sv
// rtl/ch_pkg.sv - shared defaults, FSM encoding, error indices and byte-swap helper for ch_buf
package ch_pkg;

    localparam int DEF_DW  = 64;
    localparam int DEF_AW  = 9;

    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } ch_state_e;

    // Byte reversal of one 32-bit lane; wider words reverse lane order around it.
    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/ch_sfifo.sv
// rtl/ch_sfifo.sv - synchronous first-word-fall-through FIFO with registered level
module ch_sfifo
    import ch_pkg::*;
#(
    parameter int W  = DEF_DW + 1,
    parameter int AW = DEF_AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   lvl_o,
    output logic          ovf_o,
    output logic          udf_o
);

    localparam int            DEPTH   = 2**AW;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   lvl_q, lvl_d;
    logic          push_ok;
    logic          pop_ok;

    // Level never exceeds DEPTH, so its top bit alone means full.
    assign empty_o = (lvl_q == '0);
    assign full_o  = lvl_q[AW];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign ovf_o   = push_i && full_o;
    assign udf_o   = pop_i && empty_o;
    assign data_o  = mem_q[rd_q];
    assign lvl_o   = lvl_q;

    // Pointer and level next state from the accepted push/pop pair
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (push_ok) wr_d = wr_q + PTR_ONE;
        if (pop_ok)  rd_d = rd_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   lvl_d = lvl_q + LVL_ONE;
            2'b01:   lvl_d = lvl_q - LVL_ONE;
            default: lvl_d = lvl_q;
        endcase
    end

    // Pointer and level registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    // Storage array; contents are meaningless while the level says empty
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ch_buf.sv
// rtl/ch_buf.sv - bidirectional DMA/compression channel buffer with drain FSM
module ch_buf
    import ch_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int SWAP   = 1,
    parameter int AE_LVL = 2
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          m_reset,
    input  logic          src_xfer,
    input  logic          src_last,
    input  logic [DW-1:0] src_dat_o,
    output logic          src_start,
    output logic          src_stop,
    output logic          src_end,
    input  logic [AW:0]   src_hi_thr,
    input  logic          m_src_getn,
    output logic [DW-1:0] m_src,
    output logic          m_src_last,
    output logic          m_src_empty,
    output logic          m_src_almost_empty,
    input  logic          m_dst_putn,
    input  logic [DW-1:0] m_dst,
    input  logic          m_dst_last,
    output logic          m_dst_full,
    output logic          m_dst_almost_full,
    input  logic          m_endn,
    input  logic [AW:0]   dst_hi_thr,
    input  logic          dst_xfer,
    output logic [DW-1:0] dst_dat_i,
    output logic          dst_start,
    output logic          dst_stop,
    output logic          dst_end,
    output logic [AW:0]   src_lvl,
    output logic [AW:0]   dst_lvl,
    output logic [1:0]    err,
    output logic [15:0]   ocnt
);

    localparam logic [AW:0] SRC_START_MAX = (AW+1)'(2**AW - 1);
    localparam logic [AW:0] AE_THR        = (AW+1)'(AE_LVL);

    logic          rst;
    logic [DW-1:0] src_sw, dst_sw;
    logic [DW:0]   src_head, dst_head;
    logic          src_full, src_ovf, src_udf;
    logic          dst_empty, dst_ovf, dst_udf;
    logic          dst_push_ok, dst_pop;
    ch_state_e     state_q, state_d;
    logic [1:0]    err_q, err_d;
    logic [15:0]   ocnt_q, ocnt_d;

    assign rst = wb_rst_i || m_reset;

    if (SWAP != 0) begin : g_swap
        for (genvar k = 0; k < DW/32; k++) begin : g_lane
            assign src_sw[32*k +: 32] = swap32(src_dat_o[DW-32-32*k +: 32]);
            assign dst_sw[32*k +: 32] = swap32(m_dst[DW-32-32*k +: 32]);
        end
    end else begin : g_pass
        assign src_sw = src_dat_o;
        assign dst_sw = m_dst;
    end

    ch_sfifo #(.W(DW + 1), .AW(AW)) u_src_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (rst),
        .push_i  (src_xfer),
        .data_i  ({src_last, src_sw}),
        .pop_i   (!m_src_getn),
        .data_o  (src_head),
        .empty_o (m_src_empty),
        .full_o  (src_full),
        .lvl_o   (src_lvl),
        .ovf_o   (src_ovf),
        .udf_o   (src_udf)
    );

    ch_sfifo #(.W(DW + 1), .AW(AW)) u_dst_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (rst),
        .push_i  (!m_dst_putn),
        .data_i  ({m_dst_last, dst_sw}),
        .pop_i   (dst_pop),
        .data_o  (dst_head),
        .empty_o (dst_empty),
        .full_o  (m_dst_full),
        .lvl_o   (dst_lvl),
        .ovf_o   (dst_ovf),
        .udf_o   (dst_udf)
    );

    assign m_src              = src_head[DW-1:0];
    assign m_src_last         = src_head[DW];
    assign m_src_almost_empty = (src_lvl <= AE_THR);
    assign src_start          = !src_full && (src_lvl < SRC_START_MAX);
    assign src_stop           = (src_lvl >= src_hi_thr);
    assign src_end            = 1'b0;

    // The last-flagged word parks at the head until reset, so the bus cannot pop it.
    assign dst_dat_i         = dst_head[DW-1:0];
    assign dst_end           = !dst_empty && dst_head[DW];
    assign dst_pop           = dst_xfer && !dst_end;
    assign dst_push_ok       = !m_dst_putn && !m_dst_full;
    assign m_dst_almost_full = (dst_lvl >= dst_hi_thr);

    assign err  = err_q;
    assign ocnt = ocnt_q;

    // Drain FSM next state and bus-side burst hints
    always_comb begin
        state_d   = state_q;
        dst_start = 1'b0;
        dst_stop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!m_endn)          state_d = ST_DRAIN;
                else if (dst_push_ok) state_d = ST_STREAM;
            end
            ST_STREAM: if (!m_endn)  state_d = ST_DRAIN;
            ST_DRAIN:  if (dst_end)  state_d = ST_DONE;
            default:                 state_d = ST_DONE;
        endcase
        dst_start = (dst_lvl >= dst_hi_thr) ||
                    ((state_q == ST_DRAIN) && !dst_empty && !dst_end);
        dst_stop  = (state_q == ST_STREAM) && (dst_lvl < dst_hi_thr);
    end

    // Sticky error flags and saturating count of non-last engine words
    always_comb begin
        err_d  = err_q;
        ocnt_d = ocnt_q;
        if (src_ovf || dst_ovf) err_d[ERR_OVF] = 1'b1;
        if (src_udf || dst_udf) err_d[ERR_UDF] = 1'b1;
        if (dst_push_ok && !m_dst_last && (ocnt_q != 16'hFFFF)) ocnt_d = ocnt_q + 16'd1;
    end

    // Control state registers
    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            ocnt_q  <= ocnt_d;
        end
    end

endmodule

// File: tb/tb_ch_buf.sv
// tb/tb_ch_buf.sv - scoreboard bench for ch_buf with a queue-based reference model
module tb_ch_buf;

    localparam int DW    = 64;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int S_IDLE = 0, S_STREAM = 1, S_DRAIN = 2, S_DONE = 3;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          m_reset = 1'b0;
    logic          src_xfer = 1'b0;
    logic          src_last = 1'b0;
    logic [DW-1:0] src_dat_o = '0;
    logic          src_start, src_stop, src_end;
    logic [AW:0]   src_hi_thr = 4'd6;
    logic          m_src_getn = 1'b1;
    logic [DW-1:0] m_src;
    logic          m_src_last, m_src_empty, m_src_almost_empty;
    logic          m_dst_putn = 1'b1;
    logic [DW-1:0] m_dst = '0;
    logic          m_dst_last = 1'b0;
    logic          m_dst_full, m_dst_almost_full;
    logic          m_endn = 1'b1;
    logic [AW:0]   dst_hi_thr = 4'd4;
    logic          dst_xfer = 1'b0;
    logic [DW-1:0] dst_dat_i;
    logic          dst_start, dst_stop, dst_end;
    logic [AW:0]   src_lvl, dst_lvl;
    logic [1:0]    err;
    logic [15:0]   ocnt;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic [DW:0] ms[$];
    logic [DW:0] md[$];
    logic [1:0]  merr  = 2'b00;
    logic [15:0] mocnt = 16'd0;
    int          mst   = S_IDLE;

    ch_buf #(.DW(DW), .AW(AW), .SWAP(1), .AE_LVL(2)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .m_reset(m_reset),
        .src_xfer(src_xfer), .src_last(src_last), .src_dat_o(src_dat_o),
        .src_start(src_start), .src_stop(src_stop), .src_end(src_end),
        .src_hi_thr(src_hi_thr), .m_src_getn(m_src_getn), .m_src(m_src),
        .m_src_last(m_src_last), .m_src_empty(m_src_empty),
        .m_src_almost_empty(m_src_almost_empty), .m_dst_putn(m_dst_putn),
        .m_dst(m_dst), .m_dst_last(m_dst_last), .m_dst_full(m_dst_full),
        .m_dst_almost_full(m_dst_almost_full), .m_endn(m_endn),
        .dst_hi_thr(dst_hi_thr), .dst_xfer(dst_xfer), .dst_dat_i(dst_dat_i),
        .dst_start(dst_start), .dst_stop(dst_stop), .dst_end(dst_end),
        .src_lvl(src_lvl), .dst_lvl(dst_lvl), .err(err), .ocnt(ocnt)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [DW-1:0] bswap(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int b = 0; b < DW/8; b++) r[8*b +: 8] = d[8*(DW/8-1-b) +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Reference model: applies each edge's stimulus to plain queues
    always @(posedge wb_clk_i) begin : model
        bit s_full, s_empty, d_full, d_empty, d_end, d_acc;
        if (wb_rst_i || m_reset) begin
            ms.delete();
            md.delete();
            merr  = 2'b00;
            mocnt = 16'd0;
            mst   = S_IDLE;
        end else begin
            s_full  = (ms.size() == DEPTH);
            s_empty = (ms.size() == 0);
            d_full  = (md.size() == DEPTH);
            d_empty = (md.size() == 0);
            d_end   = !d_empty && md[0][DW];
            if (!m_src_getn) begin
                if (s_empty) merr[1] = 1'b1;
                else void'(ms.pop_front());
            end
            if (src_xfer) begin
                if (s_full) merr[0] = 1'b1;
                else ms.push_back({src_last, bswap(src_dat_o)});
            end
            if (dst_xfer && !d_end) begin
                if (d_empty) merr[1] = 1'b1;
                else void'(md.pop_front());
            end
            d_acc = !m_dst_putn && !d_full;
            if (!m_dst_putn) begin
                if (d_full) merr[0] = 1'b1;
                else md.push_back({m_dst_last, bswap(m_dst)});
            end
            if (d_acc && !m_dst_last && mocnt != 16'hFFFF) mocnt = mocnt + 16'd1;
            case (mst)
                S_IDLE:   if (!m_endn) mst = S_DRAIN; else if (d_acc) mst = S_STREAM;
                S_STREAM: if (!m_endn) mst = S_DRAIN;
                S_DRAIN:  if (d_end) mst = S_DONE;
                default:  mst = S_DONE;
            endcase
        end
    end

    // Monitor: compares DUT outputs and head words against the model mid-cycle
    always @(negedge wb_clk_i) begin : monitor
        int ss, ds;
        bit mend;
        ss   = ms.size();
        ds   = md.size();
        mend = (ds > 0) && md[0][DW];
        chk("src_lvl",   64'(src_lvl), 64'(ss));
        chk("src_empty", 64'(m_src_empty), 64'(ss == 0));
        chk("src_start", 64'(src_start), 64'(ss < DEPTH - 1));
        chk("src_stop",  64'(src_stop), 64'(ss >= int'(src_hi_thr)));
        chk("src_ae",    64'(m_src_almost_empty), 64'(ss <= 2));
        chk("src_end",   64'(src_end), 64'd0);
        if (ss > 0) begin
            chk("src_head",      m_src, ms[0][DW-1:0]);
            chk("src_head_last", 64'(m_src_last), 64'(ms[0][DW]));
        end
        chk("dst_lvl",   64'(dst_lvl), 64'(ds));
        chk("dst_full",  64'(m_dst_full), 64'(ds == DEPTH));
        chk("dst_af",    64'(m_dst_almost_full), 64'(ds >= int'(dst_hi_thr)));
        chk("dst_end",   64'(dst_end), 64'(mend));
        chk("dst_start", 64'(dst_start),
            64'((ds >= int'(dst_hi_thr)) || (mst == S_DRAIN && ds > 0 && !mend)));
        chk("dst_stop",  64'(dst_stop), 64'(mst == S_STREAM && ds < int'(dst_hi_thr)));
        if (ds > 0) chk("dst_head", dst_dat_i, md[0][DW-1:0]);
        chk("err",  64'(err), 64'(merr));
        chk("ocnt", 64'(ocnt), 64'(mocnt));
    end

    task automatic idle_inputs();
        src_xfer = 0; src_last = 0; m_src_getn = 1;
        m_dst_putn = 1; m_dst_last = 0; dst_xfer = 0; m_endn = 1;
        m_reset = 0; wb_rst_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        wb_rst_i = 1;
        tick();
        wb_rst_i = 0;
    endtask

    task automatic dst_push(input logic last);
        m_dst_putn = 0; m_dst_last = last; m_dst = {$urandom, $urandom};
        tick();
        m_dst_putn = 1; m_dst_last = 0;
    endtask

    initial begin
        int p_sx, p_sp, p_dp, p_dx;
        tick(); tick();
        do_reset();
        @(negedge wb_clk_i);
        chk("rst_src_start", 64'(src_start), 64'd1);
        chk("rst_dst_start", 64'(dst_start), 64'd0);
        chk("rst_empty",     64'(m_src_empty), 64'd1);

        // byte swap of a marked word
        src_xfer = 1; src_last = 1; src_dat_o = 64'h0011223344556677;
        tick();
        src_xfer = 0; src_last = 0;
        @(negedge wb_clk_i);
        chk("swap_data",  m_src, 64'h7766554433221100);
        chk("swap_last",  64'(m_src_last), 64'd1);
        chk("swap_empty", 64'(m_src_empty), 64'd0);
        m_src_getn = 0; tick(); m_src_getn = 1;

        // fill to full, then one overflowing push
        for (int i = 0; i < 9; i++) begin
            src_xfer = 1; src_dat_o = {$urandom, $urandom};
            tick();
        end
        src_xfer = 0;
        @(negedge wb_clk_i);
        chk("full_lvl",   64'(src_lvl), 64'd8);
        chk("full_start", 64'(src_start), 64'd0);
        chk("full_err",   64'(err), 64'd1);
        m_src_getn = 0; tick(); m_src_getn = 1;
        @(negedge wb_clk_i);
        chk("pop_lvl", 64'(src_lvl), 64'd7);

        // drop to 4, then simultaneous push and pop
        m_src_getn = 0; tick(); tick(); tick();
        src_xfer = 1; src_dat_o = {$urandom, $urandom};
        tick();
        src_xfer = 0; m_src_getn = 1;
        @(negedge wb_clk_i);
        chk("pushpop_lvl", 64'(src_lvl), 64'd4);
        m_src_getn = 0;
        for (int i = 0; i < 5; i++) tick();
        m_src_getn = 1;
        @(negedge wb_clk_i);
        chk("udf_err", 64'(err), 64'd3);

        // destination watermark
        do_reset();
        dst_hi_thr = 4'd4;
        dst_push(0); dst_push(0); dst_push(0);
        @(negedge wb_clk_i);
        chk("wm3_start", 64'(dst_start), 64'd0);
        chk("wm3_stop",  64'(dst_stop), 64'd1);
        dst_push(0);
        @(negedge wb_clk_i);
        chk("wm4_start", 64'(dst_start), 64'd1);

        // end-of-stream drain
        do_reset();
        dst_push(0); dst_push(0); dst_push(1);
        m_endn = 0; tick(); m_endn = 1;
        @(negedge wb_clk_i);
        chk("drain_start", 64'(dst_start), 64'd1);
        dst_xfer = 1; tick(); tick(); dst_xfer = 0;
        @(negedge wb_clk_i);
        chk("drain_end",   64'(dst_end), 64'd1);
        chk("drain_start0", 64'(dst_start), 64'd0);
        chk("drain_ocnt",  64'(ocnt), 64'd2);
        dst_xfer = 1; tick(); tick(); tick(); dst_xfer = 0;
        @(negedge wb_clk_i);
        chk("held_lvl", 64'(dst_lvl), 64'd1);
        chk("held_err", 64'(err), 64'd0);

        // channel clear mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) dst_push(0);
        src_xfer = 1; tick(); tick(); src_xfer = 0;
        m_reset = 1; tick(); m_reset = 0;
        @(negedge wb_clk_i);
        chk("mrst_dst_lvl", 64'(dst_lvl), 64'd0);
        chk("mrst_src_lvl", 64'(src_lvl), 64'd0);
        chk("mrst_ocnt",    64'(ocnt), 64'd0);
        dst_push(0);
        @(negedge wb_clk_i);
        chk("mrst_stream", 64'(dst_stop), 64'd1);

        // randomized traffic with shifting biases
        p_sx = 50; p_sp = 50; p_dp = 50; p_dx = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                p_sx = $urandom_range(10, 90); p_sp = $urandom_range(10, 90);
                p_dp = $urandom_range(10, 90); p_dx = $urandom_range(10, 90);
            end
            if (c % 100 == 0) begin
                src_hi_thr = 4'($urandom_range(0, 12));
                dst_hi_thr = 4'($urandom_range(0, 12));
            end
            src_xfer   = ($urandom_range(0, 99) < p_sx);
            src_last   = ($urandom_range(0, 7) == 0);
            src_dat_o  = {$urandom, $urandom};
            m_src_getn = !($urandom_range(0, 99) < p_sp);
            m_dst_putn = !($urandom_range(0, 99) < p_dp);
            m_dst_last = ($urandom_range(0, 19) == 0);
            m_dst      = {$urandom, $urandom};
            dst_xfer   = ($urandom_range(0, 99) < p_dx);
            m_endn     = ($urandom_range(0, 49) != 0);
            m_reset    = ($urandom_range(0, 149) == 0);
            wb_rst_i   = ($urandom_range(0, 999) == 0);
            tick();
        end
        idle_inputs();
        tick();
        @(negedge wb_clk_i);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
